// File: rtl/rd_addr_n_arbiter_pkg.sv
// rd_addr_n_arbiter_pkg: mode encodings and width helper shared by the N-memory arbiter
package rd_addr_n_arbiter_pkg;
  typedef enum logic [1:0] {STP = 2'b00, EVP = 2'b01, EVB = 2'b10, RST = 2'b11} mode_t;
  // ceil(log2(v)), but never below 1 so single-entry sizes still get a bit
  function automatic int log2c(input int v);
    int r;
    r = 1;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rd_addr_n_arbiter_rr.sv
// rd_addr_n_arbiter_rr: fixed-priority and round-robin winner search over masked requests
module rd_addr_n_arbiter_rr
  import rd_addr_n_arbiter_pkg::*;
#(
  parameter int NUM_CH = 2,
  localparam int CHW = log2c(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_masked,
  input  logic [CHW-1:0]    rr_ptr,
  output logic [CHW-1:0]    fp_win,
  output logic [CHW-1:0]    rr_win,
  output logic              any_valid
);
  logic [CHW-1:0] idx;
  // descending scan so the last hit is the highest-priority one
  always_comb begin
    fp_win = '0;
    rr_win = '0;
    idx = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      idx = CHW'((int'(rr_ptr) + i) % NUM_CH);
      if (req_masked[CHW'(i)]) fp_win = CHW'(i);
      if (req_masked[idx]) rr_win = idx;
    end
  end
  assign any_valid = |req_masked;
endmodule

// File: rtl/rd_addr_n_arbiter.sv
// rd_addr_n_arbiter: registered read arbiter for the N-coefficient memory with range check and response tag
module rd_addr_n_arbiter
  import rd_addr_n_arbiter_pkg::*;
#(
  parameter int n_size = 8,
  parameter int NUM_CH = 2,
  parameter int INSTR_W = 8,
  localparam int AW = log2c(n_size),
  localparam int CHW = log2c(NUM_CH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [INSTR_W-1:0]   instr,
  input  logic [NUM_CH-1:0]    req,
  input  logic [NUM_CH*AW-1:0] addr_flat,
  output logic [NUM_CH-1:0]    gnt,
  output logic [AW-1:0]        rd_addr_N,
  output logic                 rd_en_N,
  output logic                 rsp_valid,
  output logic [CHW-1:0]       rsp_ch,
  output logic                 addr_err
);
  mode_t mode;
  logic [NUM_CH-1:0] req_masked;
  logic [CHW-1:0] rr_ptr, fp_win, rr_win, win, rd_ch;
  logic [AW-1:0] win_addr;
  logic any_valid, grant_ok, err, issue;
  // unknown upper opcode bits fall back to the safe idle mode
  assign mode = (|instr[INSTR_W-1:2]) ? STP : mode_t'(instr[1:0]);
  assign req_masked = req & ~gnt;
  rd_addr_n_arbiter_rr #(.NUM_CH(NUM_CH)) u_rr (
    .req_masked(req_masked),
    .rr_ptr(rr_ptr),
    .fp_win(fp_win),
    .rr_win(rr_win),
    .any_valid(any_valid)
  );
  always_comb begin
    win = (mode == EVP) ? fp_win : rr_win;
    win_addr = addr_flat[int'(win)*AW +: AW];
    grant_ok = any_valid && (mode == EVP || mode == EVB);
    err = grant_ok && (int'(win_addr) >= n_size);
    issue = grant_ok && !err;
  end
  // out-of-range requests are still granted so the requester is released
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      gnt <= '0;
      rd_addr_N <= '0;
      rd_en_N <= 1'b0;
      addr_err <= 1'b0;
      rr_ptr <= '0;
      rd_ch <= '0;
      rsp_valid <= 1'b0;
      rsp_ch <= '0;
    end else begin
      gnt <= grant_ok ? NUM_CH'(1) << win : '0;
      rd_en_N <= issue;
      addr_err <= err;
      rd_addr_N <= (mode == RST) ? '0 : issue ? win_addr : rd_addr_N;
      rr_ptr <= (mode == RST) ? '0 : (mode == EVB && grant_ok) ? ((win == CHW'(NUM_CH - 1)) ? '0 : win + 1'b1) : rr_ptr;
      rd_ch <= issue ? win : rd_ch;
      rsp_valid <= rd_en_N;
      rsp_ch <= rd_en_N ? rd_ch : rsp_ch;
    end
endmodule

// File: tb/tb_rd_addr_n_arbiter.sv
// tb_rd_addr_n_arbiter: directed vectors on 2-channel, 4-channel and n_size=6 arbiter instances
module tb_rd_addr_n_arbiter;
  logic clk, rst_n;
  logic [7:0] instr2, instr4, instr6;
  logic [1:0] req2, req6, gnt2, gnt6;
  logic [3:0] req4, gnt4;
  logic [5:0] addr2, addr6;
  logic [11:0] addr4;
  logic [2:0] rd_addr2, rd_addr4, rd_addr6;
  logic rd_en2, rd_en4, rd_en6, rsp_valid2, rsp_valid4, rsp_valid6, err2, err4, err6;
  logic rsp_ch2, rsp_ch6;
  logic [1:0] rsp_ch4;
  int n_vec, n_err;
  rd_addr_n_arbiter #(.n_size(8), .NUM_CH(2), .INSTR_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .instr(instr2), .req(req2), .addr_flat(addr2),
    .gnt(gnt2), .rd_addr_N(rd_addr2), .rd_en_N(rd_en2), .rsp_valid(rsp_valid2),
    .rsp_ch(rsp_ch2), .addr_err(err2));
  rd_addr_n_arbiter #(.n_size(8), .NUM_CH(4), .INSTR_W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .instr(instr4), .req(req4), .addr_flat(addr4),
    .gnt(gnt4), .rd_addr_N(rd_addr4), .rd_en_N(rd_en4), .rsp_valid(rsp_valid4),
    .rsp_ch(rsp_ch4), .addr_err(err4));
  rd_addr_n_arbiter #(.n_size(6), .NUM_CH(2), .INSTR_W(8)) u6 (
    .clk(clk), .rst_n(rst_n), .instr(instr6), .req(req6), .addr_flat(addr6),
    .gnt(gnt6), .rd_addr_N(rd_addr6), .rd_en_N(rd_en6), .rsp_valid(rsp_valid6),
    .rsp_ch(rsp_ch6), .addr_err(err6));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    instr2 = 0; instr4 = 0; instr6 = 0;
    req2 = 0; req4 = 0; req6 = 0;
    addr2 = 0; addr4 = 0; addr6 = 0;
    repeat (2) tick();
    chk("rst_gnt", 32'(gnt2), 0);
    chk("rst_rd_addr", 32'(rd_addr2), 0);
    chk("rst_rd_en", 32'(rd_en2), 0);
    chk("rst_rsp_valid", 32'(rsp_valid2), 0);
    chk("rst_rsp_ch", 32'(rsp_ch4), 0);
    chk("rst_err", 32'(err6), 0);
    rst_n = 1'b1;
    // async reset mid-burst, with rr_ptr moved off 0 beforehand
    instr2 = 8'h02; req2 = 2'b01; addr2 = {3'd0, 3'd3};
    tick();
    chk("t1_evb_gnt", 32'(gnt2), 32'b01);
    instr2 = 8'h01; req2 = 2'b10; addr2 = {3'd4, 3'd3};
    tick();
    chk("t1_gnt", 32'(gnt2), 32'b10);
    chk("t1_rd_en", 32'(rd_en2), 1);
    chk("t1_rd_addr", 32'(rd_addr2), 4);
    chk("t1_rsp_valid", 32'(rsp_valid2), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_async_gnt", 32'(gnt2), 0);
    chk("t1_async_rd_en", 32'(rd_en2), 0);
    chk("t1_async_rd_addr", 32'(rd_addr2), 0);
    chk("t1_async_rsp_valid", 32'(rsp_valid2), 0);
    chk("t1_async_err", 32'(err2), 0);
    req2 = 2'b00;
    #2 rst_n = 1'b1;
    instr2 = 8'h02; req2 = 2'b11; addr2 = {3'd2, 3'd1};
    tick();
    chk("t1_rr_cleared", 32'(gnt2), 32'b01);
    instr2 = 8'h00; req2 = 2'b00;
    repeat (2) tick();
    // fixed priority, two channels
    instr2 = 8'h01; req2 = 2'b11; addr2 = {3'd5, 3'd3};
    tick();
    chk("t2_gnt0", 32'(gnt2), 32'b01);
    chk("t2_addr0", 32'(rd_addr2), 3);
    chk("t2_en0", 32'(rd_en2), 1);
    req2 = 2'b10;
    tick();
    chk("t2_gnt1", 32'(gnt2), 32'b10);
    chk("t2_addr1", 32'(rd_addr2), 5);
    chk("t2_rspv0", 32'(rsp_valid2), 1);
    chk("t2_rspch0", 32'(rsp_ch2), 0);
    req2 = 2'b00;
    tick();
    chk("t2_idle_gnt", 32'(gnt2), 0);
    chk("t2_idle_en", 32'(rd_en2), 0);
    chk("t2_hold_addr", 32'(rd_addr2), 5);
    chk("t2_rspv1", 32'(rsp_valid2), 1);
    chk("t2_rspch1", 32'(rsp_ch2), 1);
    tick();
    chk("t2_rspv_off", 32'(rsp_valid2), 0);
    chk("t2_rspch_hold", 32'(rsp_ch2), 1);
    req2 = 2'b01;
    tick();
    chk("t2_held_g1", 32'(gnt2), 32'b01);
    tick();
    chk("t2_held_masked", 32'(gnt2), 0);
    tick();
    chk("t2_held_g2", 32'(gnt2), 32'b01);
    req2 = 2'b00;
    repeat (2) tick();
    // EVB grant then switch to STP: response still arrives (rr_ptr=1 here)
    instr2 = 8'h02; req2 = 2'b10; addr2 = {3'd6, 3'd3};
    tick();
    chk("t6_gnt", 32'(gnt2), 32'b10);
    chk("t6_addr", 32'(rd_addr2), 6);
    instr2 = 8'h00; req2 = 2'b00;
    tick();
    chk("t6_no_gnt", 32'(gnt2), 0);
    chk("t6_rspv", 32'(rsp_valid2), 1);
    chk("t6_rspch", 32'(rsp_ch2), 1);
    // STP / RST / illegal opcode (rr_ptr wrapped to 0)
    instr2 = 8'h02; req2 = 2'b01; addr2 = {3'd6, 3'd2};
    tick();
    chk("t5_pre_gnt", 32'(gnt2), 32'b01);
    chk("t5_pre_addr", 32'(rd_addr2), 2);
    instr2 = 8'h00;
    tick();
    chk("t5_stp_gnt", 32'(gnt2), 0);
    chk("t5_stp_addr", 32'(rd_addr2), 2);
    chk("t5_stp_drain", 32'(rsp_valid2), 1);
    tick();
    chk("t5_stp_gnt2", 32'(gnt2), 0);
    chk("t5_stp_en", 32'(rd_en2), 0);
    instr2 = 8'h03;
    tick();
    chk("t5_rst_addr", 32'(rd_addr2), 0);
    chk("t5_rst_gnt", 32'(gnt2), 0);
    instr2 = 8'h05; req2 = 2'b11;
    tick();
    chk("t5_bad_gnt", 32'(gnt2), 0);
    instr2 = 8'h04;
    tick();
    chk("t5_04_gnt", 32'(gnt2), 0);
    chk("t5_04_addr", 32'(rd_addr2), 0);
    instr2 = 8'h02; addr2 = {3'd1, 3'd4};
    tick();
    chk("t5_rr_cleared", 32'(gnt2), 32'b01);
    chk("t5_rr_addr", 32'(rd_addr2), 4);
    instr2 = 8'h00; req2 = 2'b00;
    repeat (2) tick();
    // round robin across four channels
    instr4 = 8'h02; req4 = 4'b1111; addr4 = {3'd4, 3'd3, 3'd2, 3'd1};
    tick();
    chk("t3_g0", 32'(gnt4), 32'b0001);
    chk("t3_a0", 32'(rd_addr4), 1);
    req4 = 4'b1110;
    tick();
    chk("t3_g1", 32'(gnt4), 32'b0010);
    chk("t3_a1", 32'(rd_addr4), 2);
    req4 = 4'b1100;
    tick();
    chk("t3_g2", 32'(gnt4), 32'b0100);
    chk("t3_a2", 32'(rd_addr4), 3);
    req4 = 4'b1000;
    tick();
    chk("t3_g3", 32'(gnt4), 32'b1000);
    chk("t3_a3", 32'(rd_addr4), 4);
    req4 = 4'b1111;
    tick();
    chk("t3_wrap", 32'(gnt4), 32'b0001);
    chk("t3_rspch3", 32'(rsp_ch4), 3);
    req4 = 4'b0000;
    tick();
    req4 = 4'b0101;
    tick();
    chk("t3_from1", 32'(gnt4), 32'b0100);
    req4 = 4'b0001;
    tick();
    chk("t3_from3", 32'(gnt4), 32'b0001);
    instr4 = 8'h00; req4 = 4'b0000;
    repeat (2) tick();
    // range check with n_size=6
    instr6 = 8'h01; req6 = 2'b01; addr6 = {3'd0, 3'd2};
    tick();
    chk("t4_ok_en", 32'(rd_en6), 1);
    chk("t4_ok_addr", 32'(rd_addr6), 2);
    req6 = 2'b00;
    tick();
    addr6 = {3'd0, 3'd7}; req6 = 2'b01;
    tick();
    chk("t4_7_gnt", 32'(gnt6), 32'b01);
    chk("t4_7_err", 32'(err6), 1);
    chk("t4_7_en", 32'(rd_en6), 0);
    chk("t4_7_addr", 32'(rd_addr6), 2);
    req6 = 2'b00;
    tick();
    chk("t4_7_no_rsp", 32'(rsp_valid6), 0);
    chk("t4_err_clr", 32'(err6), 0);
    addr6 = {3'd0, 3'd6}; req6 = 2'b01;
    tick();
    chk("t4_6_err", 32'(err6), 1);
    chk("t4_6_en", 32'(rd_en6), 0);
    req6 = 2'b00;
    tick();
    addr6 = {3'd0, 3'd5}; req6 = 2'b01;
    tick();
    chk("t4_5_err", 32'(err6), 0);
    chk("t4_5_en", 32'(rd_en6), 1);
    chk("t4_5_addr", 32'(rd_addr6), 5);
    instr6 = 8'h00; req6 = 2'b00;
    tick();
    chk("t4_5_rsp", 32'(rsp_valid6), 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
